// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes and multiplier sequencer state encoding shared by the ALU decoder and alu_mul_seq.
package alu_pkg;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_SRL2 = 4'b1011;
   typedef enum logic [2:0] {S_IDLE, S_ADD, S_SHL, S_SHR, S_DONE} mul_state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add MUL sequencer that borrows the shared ALU (ADD/SLL/SRL) while ALUGrant is high.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Start,
   input  logic             Abort,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Product,
   output logic             ALUGrant,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   output logic [3:0]       ALUcontrol_Out,
   input  logic [WIDTH-1:0] ALUResult_In
);
   mul_state_t       state_q;
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, product_q;
   logic [CNT_W-1:0] cnt_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         product_q <= '0;
         cnt_q     <= '0;
      end else if (Abort)
         state_q <= S_IDLE;
      else
         case (state_q)
            S_IDLE: if (Start) begin
               acc_q    <= '0;
               mcand_q  <= OpA;
               mplier_q <= OpB;
               cnt_q    <= '0;
               state_q  <= (OpB == '0) ? S_DONE : S_ADD;
            end
            S_ADD: begin
               acc_q   <= ALUResult_In;
               state_q <= S_SHL;
            end
            S_SHL: begin
               mcand_q <= ALUResult_In;
               state_q <= S_SHR;
            end
            S_SHR: begin
               mplier_q <= ALUResult_In;
               cnt_q    <= cnt_q + 1'b1;
               state_q  <= (ALUResult_In == '0 || cnt_q == CNT_W'(WIDTH-1)) ? S_DONE : S_ADD;
            end
            S_DONE: begin
               product_q <= acc_q;
               state_q   <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
   // Product is presented straight from acc during DONE so it is valid in the Done cycle itself.
   always_comb begin
      Busy           = state_q != S_IDLE;
      Done           = state_q == S_DONE;
      Product        = Done ? acc_q : product_q;
      ALUGrant       = state_q inside {S_ADD, S_SHL, S_SHR};
      ALU_A          = state_q == S_ADD ? acc_q : state_q == S_SHL ? mcand_q : state_q == S_SHR ? mplier_q : '0;
      ALU_B          = state_q == S_ADD ? (mplier_q[0] ? mcand_q : '0) : ALUGrant ? WIDTH'(1) : '0;
      ALUcontrol_Out = state_q == S_ADD ? ALU_ADD : state_q == S_SHL ? ALU_SLL : state_q == S_SHR ? ALU_SRL : 4'b0000;
   end
endmodule
